// File: rtl/ysyx_040978_mux_key_table_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040978_mux_key_table_pkg
//   Shared encodings for the programmable key table.
//   - wr_op command codes (insert/update, delete, set default, clear all)
//   - write response status codes
// ---------------------------------------------------------------------------
package ysyx_040978_mux_key_table_pkg;

    typedef enum logic [1:0] {
        OP_INSERT      = 2'd0,
        OP_DELETE      = 2'd1,
        OP_SET_DEFAULT = 2'd2,
        OP_CLEAR_ALL   = 2'd3
    } wr_op_e;

    typedef enum logic [1:0] {
        ST_OK_NEW     = 2'd0,
        ST_OK_UPDATE  = 2'd1,
        ST_ERR_FULL   = 2'd2,
        ST_ERR_ABSENT = 2'd3
    } wr_status_e;

endpackage

// File: rtl/ysyx_040978_key_match.sv
// ---------------------------------------------------------------------------
// ysyx_040978_key_match
//   Combinational comparator bank: compares one key against every table
//   entry and returns the one-hot match vector, a hit flag and the data of
//   the matching entry (zero when nothing matches).
//
//   Ports:
//     key          in   search key
//     entry_valid  in   per-entry valid bits
//     entry_key    in   per-entry stored keys
//     entry_data   in   per-entry stored data
//     match        out  one-hot match vector (valid & key equal)
//     hit          out  any entry matched
//     match_data   out  data of the matched entry
// ---------------------------------------------------------------------------
module ysyx_040978_key_match #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 32
) (
    input  logic [KEY_LEN-1:0]                 key,
    input  logic [NR_KEY-1:0]                  entry_valid,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]     entry_key,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0]    entry_data,
    output logic [NR_KEY-1:0]                  match,
    output logic                               hit,
    output logic [DATA_LEN-1:0]                match_data
);

    genvar gi;
    generate
        for (gi = 0; gi < NR_KEY; gi++) begin : g_cmp
            assign match[gi] = entry_valid[gi] && (entry_key[gi] == key);
        end
    endgenerate

    assign hit = |match;

    // Keys are unique in the table, so at most one bit of match is set and
    // an AND-OR select yields exactly that entry's data.
    always_comb begin
        match_data = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (match[i]) begin
                match_data = match_data | entry_data[i];
            end
        end
    end

endmodule

// File: rtl/ysyx_040978_mux_key_table.sv
// ---------------------------------------------------------------------------
// ysyx_040978_mux_key_table
//   Run-time programmable key -> data table with a default value.
//   Writes are always accepted and answered one cycle later with a status.
//   Lookups go through a one-stage valid/ready pipeline; a lookup issued in
//   the same cycle as a write observes the table before that write.
//
//   Ports:
//     clock, reset_n                 clock / async active-low reset
//     wr_valid, wr_op, wr_key,
//     wr_data                        write command
//     wr_resp_valid, wr_resp_status  registered write response
//     lk_valid, lk_ready, lk_key     lookup request channel
//     res_valid, res_ready,
//     res_data, res_hit              lookup result channel
//     count, full                    occupancy
// ---------------------------------------------------------------------------
module ysyx_040978_mux_key_table
    import ysyx_040978_mux_key_table_pkg::*;
#(
    parameter int                     NR_KEY      = 4,
    parameter int                     KEY_LEN     = 8,
    parameter int                     DATA_LEN    = 32,
    parameter logic [DATA_LEN-1:0]    DEFAULT_RST = '0,
    localparam int                    CW          = $clog2(NR_KEY + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [1:0]            wr_op,
    input  logic [KEY_LEN-1:0]    wr_key,
    input  logic [DATA_LEN-1:0]   wr_data,
    output logic                  wr_resp_valid,
    output logic [1:0]            wr_resp_status,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [KEY_LEN-1:0]    lk_key,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_LEN-1:0]   res_data,
    output logic                  res_hit,
    output logic [CW-1:0]         count,
    output logic                  full
);

    // ---------------- state ----------------
    logic [NR_KEY-1:0]                 valid_q, valid_d;
    logic [NR_KEY-1:0][KEY_LEN-1:0]    key_q;
    logic [NR_KEY-1:0][DATA_LEN-1:0]   data_q;
    logic [DATA_LEN-1:0]               default_q, default_d;
    logic [CW-1:0]                     count_q, count_d;
    logic                              full_q, full_d;
    logic                              wr_resp_valid_q, wr_resp_valid_d;
    logic [1:0]                        wr_resp_status_q, wr_resp_status_d;
    logic                              res_valid_q, res_valid_d;
    logic [DATA_LEN-1:0]               res_data_q, res_data_d;
    logic                              res_hit_q, res_hit_d;

    // One-hot entry write enable for the key/data storage.
    logic [NR_KEY-1:0]                 ent_we;

    // ---------------- comparator banks ----------------
    logic [NR_KEY-1:0]    wr_match;
    logic                 wr_hit;
    logic [DATA_LEN-1:0]  wr_match_data;
    logic [NR_KEY-1:0]    lk_match;
    logic                 lk_hit;
    logic [DATA_LEN-1:0]  lk_match_data;

    ysyx_040978_key_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_wr_match (
        .key         (wr_key),
        .entry_valid (valid_q),
        .entry_key   (key_q),
        .entry_data  (data_q),
        .match       (wr_match),
        .hit         (wr_hit),
        .match_data  (wr_match_data)
    );

    ysyx_040978_key_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_lk_match (
        .key         (lk_key),
        .entry_valid (valid_q),
        .entry_key   (key_q),
        .entry_data  (data_q),
        .match       (lk_match),
        .hit         (lk_hit),
        .match_data  (lk_match_data)
    );

    // The write path only needs the match vector; its data output is idle.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_match_data;

    // ---------------- lowest free entry ----------------
    logic [NR_KEY-1:0] free_onehot;
    logic              free_any;

    // Scan from the top down so the last assignment wins: lowest index.
    always_comb begin
        free_onehot = '0;
        free_any    = 1'b0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_onehot    = '0;
                free_onehot[i] = 1'b1;
                free_any       = 1'b1;
            end
        end
    end

    // ---------------- write command ----------------
    always_comb begin
        valid_d          = valid_q;
        default_d        = default_q;
        count_d          = count_q;
        ent_we           = '0;
        wr_resp_valid_d  = wr_valid;
        wr_resp_status_d = wr_resp_status_q;
        if (wr_valid) begin
            case (wr_op)
                OP_INSERT: begin
                    if (wr_hit) begin
                        ent_we           = wr_match;
                        wr_resp_status_d = ST_OK_UPDATE;
                    end else if (free_any) begin
                        ent_we           = free_onehot;
                        valid_d          = valid_q | free_onehot;
                        count_d          = count_q + CW'(1);
                        wr_resp_status_d = ST_OK_NEW;
                    end else begin
                        wr_resp_status_d = ST_ERR_FULL;
                    end
                end
                OP_DELETE: begin
                    if (wr_hit) begin
                        valid_d          = valid_q & ~wr_match;
                        count_d          = count_q - CW'(1);
                        wr_resp_status_d = ST_OK_UPDATE;
                    end else begin
                        wr_resp_status_d = ST_ERR_ABSENT;
                    end
                end
                OP_SET_DEFAULT: begin
                    default_d        = wr_data;
                    wr_resp_status_d = ST_OK_UPDATE;
                end
                default: begin // OP_CLEAR_ALL
                    valid_d          = '0;
                    count_d          = '0;
                    wr_resp_status_d = ST_OK_UPDATE;
                end
            endcase
        end
        full_d = (count_d == CW'(NR_KEY));
    end

    // ---------------- lookup pipeline ----------------
    assign lk_ready = !res_valid_q || res_ready;

    // Result uses the pre-write table and default, giving read-before-write.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_hit_d   = res_hit_q;
        if (lk_valid && lk_ready) begin
            res_valid_d = 1'b1;
            res_hit_d   = lk_hit;
            res_data_d  = lk_hit ? lk_match_data : default_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q          <= '0;
            default_q        <= DEFAULT_RST;
            count_q          <= '0;
            full_q           <= 1'b0;
            wr_resp_valid_q  <= 1'b0;
            wr_resp_status_q <= 2'd0;
            res_valid_q      <= 1'b0;
            res_data_q       <= '0;
            res_hit_q        <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            default_q        <= default_d;
            count_q          <= count_d;
            full_q           <= full_d;
            wr_resp_valid_q  <= wr_resp_valid_d;
            wr_resp_status_q <= wr_resp_status_d;
            res_valid_q      <= res_valid_d;
            res_data_q       <= res_data_d;
            res_hit_q        <= res_hit_d;
        end
    end

    // Key/data storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NR_KEY; i++) begin
            if (ent_we[i]) begin
                key_q[i]  <= wr_key;
                data_q[i] <= wr_data;
            end
        end
    end

    assign wr_resp_valid  = wr_resp_valid_q;
    assign wr_resp_status = wr_resp_status_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_hit        = res_hit_q;
    assign count          = count_q;
    assign full           = full_q;

endmodule
